seq_detector_param: RTL

//  Runtime-programmable serial bit-pattern detector, Moore style, generalising the fixed 1011 FSMs.

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/seq_window_cmp.sv | 23 ++
 rtl/seq_detector_param.sv | 97 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared width helper and overlap mode constants for the pattern detector
package seq_det_pkg;

   localparam logic MODE_OVL    = 1'b1;
   localparam logic MODE_NONOVL = 1'b0;

   // Bits needed to hold a length of 0..max_len inclusive.
   function automatic int seq_len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_window_cmp.sv
// rtl/seq_window_cmp.sv - masked compare of the history window against the pattern
// Only the low i_len bits take part; bits at or above i_len are ignored.
module seq_window_cmp #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic [MAX_LEN-1:0] i_hist,
   input  logic [MAX_LEN-1:0] i_pat,
   input  logic [LEN_W-1:0]   i_len,
   output logic               o_eq
);

   logic [MAX_LEN-1:0] w_mask;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         w_mask[i] = (i < int'(i_len));
      end
      o_eq = (((i_hist ^ i_pat) & w_mask) == '0);
   end

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial pattern detector with saturating match count
// Moore style: o_y is registered and pulses the cycle after the final pattern bit is sampled.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = seq_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_cfg_load,
   input  logic [MAX_LEN-1:0] i_pattern,
   input  logic [LEN_W-1:0]   i_len,
   input  logic               i_overlap,
   input  logic               i_en,
   input  logic               i_x,
   input  logic               i_cnt_clr,
   output logic               o_y,
   output logic [CNT_W-1:0]   o_match_cnt
);

   localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   logic [MAX_LEN-1:0] r_cfg_pat;
   logic [LEN_W-1:0]   r_cfg_len;
   logic               r_cfg_ovl;
   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic               r_y;
   logic [CNT_W-1:0]   r_cnt;

   logic [MAX_LEN-1:0] w_hist_nxt;
   logic [LEN_W-1:0]   w_fill_inc;
   logic               w_accept;
   logic               w_fill_ok;
   logic               w_cmp_eq;
   logic               w_hit;

   seq_window_cmp #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_cmp (
      .i_hist (w_hist_nxt),
      .i_pat  (r_cfg_pat),
      .i_len  (r_cfg_len),
      .o_eq   (w_cmp_eq)
   );

   // Match is judged on the window as it will look after this bit shifts in.
   always_comb begin
      w_accept   = i_en & ~i_cfg_load;
      w_hist_nxt = {r_hist[MAX_LEN-2:0], i_x};
      w_fill_inc = (r_fill == C_MAX_LEN) ? r_fill : r_fill + 1'b1;
      w_fill_ok  = (({1'b0, r_fill} + 1'b1) >= {1'b0, r_cfg_len});
      w_hit      = w_accept & w_fill_ok & w_cmp_eq & (r_cfg_len != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg_pat <= '0;
         r_cfg_len <= '0;
         r_cfg_ovl <= MODE_NONOVL;
         r_hist    <= '0;
         r_fill    <= '0;
         r_y       <= 1'b0;
      end else if (i_cfg_load) begin
         r_cfg_pat <= i_pattern;
         r_cfg_len <= (i_len > C_MAX_LEN) ? C_MAX_LEN : i_len;
         r_cfg_ovl <= i_overlap;
         r_hist    <= '0;
         r_fill    <= '0;
         r_y       <= 1'b0;
      end else if (i_en) begin
         r_hist <= w_hist_nxt;
         r_fill <= (w_hit && r_cfg_ovl == MODE_NONOVL) ? '0 : w_fill_inc;
         r_y    <= w_hit;
      end else begin
         r_y <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_hit && r_cnt != C_CNT_MAX) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_y         = r_y;
   assign o_match_cnt = r_cnt;

endmodule
